eth_axis_header_rx: RTL and testbench
=====================================

// Module: eth_axis_header_rx
// PURPOSE
// Receive-side Ethernet header parser on the MAC RX AXI-Stream (8-bit, frame-FIFO output of the MII MAC).
// Consumes each frame and captures the 14-byte header (dest MAC, src MAC, EtherType) into a header handshake.
// Forwards the remaining payload bytes on an AXI-Stream source.
// Optionally drops frames addressed to neither LOCAL_MAC nor broadcast. Feeds the ARP/IP receive blocks.
// PARAMETERS
// ENABLE_MAC_FILTER  0         1: drop frames whose dest is not LOCAL_MAC or ff:ff:ff:ff:ff:ff
// LOCAL_MAC          48'h0     station address used by the filter (byte0 = bits [47:40])
// PORTS
// clk               in   1   single clock for all logic
// reset             in   1   synchronous, active-high
// s_axis_tdata      in   8   frame bytes from MAC RX FIFO
// s_axis_tvalid     in   1
// s_axis_tready     out  1
// s_axis_tlast      in   1   last byte of frame
// s_axis_tuser      in   1   bad frame/FCS flag, valid with tlast
// m_hdr_valid       out  1   header fields valid; held until m_hdr_ready
// m_hdr_ready       in   1
// m_dest_mac        out  48  bytes 0-5, byte0 in [47:40]
// m_src_mac         out  48  bytes 6-11, byte6 in [47:40]
// m_ethertype       out  16  bytes 12-13, byte12 in [15:8]
// m_axis_tdata      out  8   payload bytes (frame byte 14 onward)
// m_axis_tvalid     out  1
// m_axis_tready     in   1
// m_axis_tlast      out  1
// m_axis_tuser      out  1   copy of s_axis_tuser on last byte
// busy              out  1   high while state != HEADER or hdr_cnt != 0
// err_short_frame   out  1   1-cycle pulse: tlast seen at or before header byte 13
// frame_dropped     out  1   1-cycle pulse: frame rejected by MAC filter (at byte 13 accept)
// BEHAVIOUR
// Reset: state=HEADER, hdr_cnt=0, all valids/pulses/busy/s_axis_tready=0, header fields=0.
// States: HEADER (capture bytes 0-13), PAYLOAD (forward), DROP (sink until tlast).
// Transfers: a byte moves on tvalid&&tready only.
// HEADER: s_axis_tready = !m_hdr_valid, so no new header is captured until the previous one is accepted.
//  - Each accepted byte is written into its field by hdr_cnt (4-bit, 0..13); hdr_cnt increments.
//  - tlast on byte 0..13: pulse err_short_frame, no m_hdr_valid, hdr_cnt=0, stay HEADER (frame discarded).
//  - Byte 13 accepted without tlast:
//    - If the filter is enabled and the frame is rejected: pulse frame_dropped, go to DROP.
//    - Otherwise: m_hdr_valid=1 on the next cycle, go to PAYLOAD.
//    - hdr_cnt=0 in both cases.
//  - Filter compares the complete dest (including byte 5 already registered) at byte 13.
// PAYLOAD: s_axis_tready = !m_axis_tvalid || m_axis_tready (single registered output stage).
//  - Latency: payload byte appears on m_axis one cycle after acceptance; full throughput 1 byte/clk.
//  - Accepted byte with tlast: m_axis_tlast/tuser registered with it; next state HEADER.
//  - m_hdr_valid and the payload stream are independent; header may be accepted before, during or after payload.
//  - m_hdr_valid clears on the cycle after m_hdr_ready&&m_hdr_valid; fields stable while valid.
// DROP: s_axis_tready=1; bytes discarded; on tlast go to HEADER. No m_axis or m_hdr activity.
// Simultaneous: hdr_ready in the cycle before a HEADER byte would be offered gives one bubble (tready low that cycle).
// m_axis_tvalid never drops without m_axis_tready; tdata/tlast/tuser are stable while stalled.
// Reset mid-frame: outputs return to reset values immediately on the clock edge.
//  - Partial header/payload is lost.
//  - Upstream MAC FIFO shares reset, so no resync state is needed.
// s_axis_tuser is ignored except on tlast in PAYLOAD; frames flagged bad in header phase are still handled by the tlast rules.
// STRUCTURE
// eth_pkg: typedef logic [47:0] mac_addr_t; typedef logic [15:0] ethertype_t;
//   localparam ETH_HDR_BYTES=14; localparam mac_addr_t ETH_BROADCAST=48'hffff_ffff_ffff.
// State enum (HEADER, PAYLOAD, DROP) is local to the module.
// Sub-module: axis_reg_stage (8-bit data + tlast + tuser, registered valid/ready slice) for the payload output.
// TESTING
// 1. 60-byte frame dest=02:00:00:00:00:01 src=02:00:00:00:00:02 type=0x0800, payload 0x00..0x2D
//    -> header fields exact, 46 payload bytes in order, tlast on 0x2D, tuser=0.
// 2. Same frame with m_axis_tready toggling 50% and m_hdr_ready held low 100 cycles
//    -> no byte lost/duplicated; next frame's byte0 not accepted until hdr accepted.
// 3. 10-byte frame with tlast on byte 9 -> err_short_frame one pulse, no m_hdr_valid, no m_axis_tvalid.
//    Following good frame parsed correctly.
// 4. ENABLE_MAC_FILTER=1, LOCAL_MAC=02:00:00:00:00:01: dest=02:00:00:00:00:09 -> frame_dropped pulse, nothing out.
//    dest=ff:ff:ff:ff:ff:ff -> passed.
// 5. Frame with s_axis_tuser=1 on tlast -> m_axis_tuser=1 on last payload byte only.
// 6. reset asserted at payload byte 20 -> next cycle all valids 0, busy 0.
//    Next complete frame parsed with correct header.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet types and constants for the RX header parser.
package eth_pkg;

    typedef logic [47:0] mac_addr_t;
    typedef logic [15:0] ethertype_t;

    localparam int unsigned ETH_HDR_BYTES = 14;
    localparam mac_addr_t   ETH_BROADCAST = 48'hffff_ffff_ffff;

    // One byte-wide AXI-Stream beat as held in the output slice
    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } axis_beat_t;

endpackage

// File: rtl/axis_reg_stage.sv
// Single registered valid/ready slice for an 8-bit AXI-Stream with tlast/tuser.
module axis_reg_stage
    import eth_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    input  logic       s_tuser,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    output logic       m_tuser
);

    axis_beat_t beat;
    logic       valid;

    // Accept a new beat whenever the held one is empty or leaving this cycle
    assign s_tready = !valid || m_tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            beat  <= '0;
        end else if (s_tvalid && s_tready) begin
            valid <= 1'b1;
            beat  <= '{data: s_tdata, last: s_tlast, user: s_tuser};
        end else if (m_tready) begin
            valid <= 1'b0;
        end
    end

    assign m_tdata  = beat.data;
    assign m_tlast  = beat.last;
    assign m_tuser  = beat.user;
    assign m_tvalid = valid;

endmodule

// File: rtl/eth_axis_header_rx.sv
// Ethernet RX header parser: splits MAC frames into a header handshake and a payload stream,
// with optional destination-address filtering.
module eth_axis_header_rx
    import eth_pkg::*;
#(
    parameter bit          ENABLE_MAC_FILTER = 1'b0,
    parameter logic [47:0] LOCAL_MAC         = 48'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        m_hdr_valid,
    input  logic        m_hdr_ready,
    output logic [47:0] m_dest_mac,
    output logic [47:0] m_src_mac,
    output logic [15:0] m_ethertype,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        busy,
    output logic        err_short_frame,
    output logic        frame_dropped
);

    typedef enum logic [1:0] {
        ST_HEADER,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    localparam logic [3:0] HDR_LAST = 4'(ETH_HDR_BYTES - 1);

    state_t     state, state_next;
    logic [3:0] hdr_cnt, cnt_next;
    logic       run;
    logic       hdr_valid_next, err_next, drop_next, busy_next;
    logic       hdr_wr;
    logic       stage_valid, stage_ready;
    logic       dest_ok;

    assign dest_ok = (mac_addr_t'(m_dest_mac) == LOCAL_MAC) ||
                     (mac_addr_t'(m_dest_mac) == ETH_BROADCAST);

    // State and registered status outputs; run holds tready low for the cycle after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_HEADER;
            hdr_cnt         <= 4'd0;
            run             <= 1'b0;
            m_hdr_valid     <= 1'b0;
            err_short_frame <= 1'b0;
            frame_dropped   <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_next;
            hdr_cnt         <= cnt_next;
            run             <= 1'b1;
            m_hdr_valid     <= hdr_valid_next;
            err_short_frame <= err_next;
            frame_dropped   <= drop_next;
            busy            <= busy_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = hdr_cnt;
        hdr_valid_next = m_hdr_valid && !m_hdr_ready;
        err_next       = 1'b0;
        drop_next      = 1'b0;
        hdr_wr         = 1'b0;
        stage_valid    = 1'b0;
        s_axis_tready  = 1'b0;

        if (run) begin
            unique case (state)
                ST_HEADER: begin
                    // A pending header blocks the next frame until the consumer takes it
                    s_axis_tready = !m_hdr_valid;
                    if (s_axis_tvalid && !m_hdr_valid) begin
                        hdr_wr = 1'b1;
                        if (s_axis_tlast) begin
                            err_next = 1'b1;
                            cnt_next = 4'd0;
                        end else if (hdr_cnt == HDR_LAST) begin
                            cnt_next = 4'd0;
                            if (ENABLE_MAC_FILTER && !dest_ok) begin
                                drop_next  = 1'b1;
                                state_next = ST_DROP;
                            end else begin
                                hdr_valid_next = 1'b1;
                                state_next     = ST_PAYLOAD;
                            end
                        end else begin
                            cnt_next = hdr_cnt + 4'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    s_axis_tready = stage_ready;
                    stage_valid   = s_axis_tvalid;
                    if (s_axis_tvalid && stage_ready && s_axis_tlast) begin
                        state_next = ST_HEADER;
                    end
                end
                ST_DROP: begin
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_next = ST_HEADER;
                    end
                end
                default: state_next = ST_HEADER;
            endcase
        end

        busy_next = (state_next != ST_HEADER) || (cnt_next != 4'd0);
    end

    // Header bytes arrive in order, so each field is filled by shifting in its byte range
    always_ff @(posedge clk) begin
        if (reset) begin
            m_dest_mac  <= 48'd0;
            m_src_mac   <= 48'd0;
            m_ethertype <= 16'd0;
        end else if (hdr_wr) begin
            if (hdr_cnt < 4'd6) begin
                m_dest_mac <= {m_dest_mac[39:0], s_axis_tdata};
            end else if (hdr_cnt < 4'd12) begin
                m_src_mac <= {m_src_mac[39:0], s_axis_tdata};
            end else begin
                m_ethertype <= {m_ethertype[7:0], s_axis_tdata};
            end
        end
    end

    axis_reg_stage u_payload_stage (
        .clk      (clk),
        .reset    (reset),
        .s_tdata  (s_axis_tdata),
        .s_tvalid (stage_valid),
        .s_tready (stage_ready),
        .s_tlast  (s_axis_tlast),
        .s_tuser  (s_axis_tuser),
        .m_tdata  (m_axis_tdata),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready),
        .m_tlast  (m_axis_tlast),
        .m_tuser  (m_axis_tuser)
    );

endmodule

// File: tb/tb_eth_axis_header_rx.sv
// Directed self-checking bench for eth_axis_header_rx with the MAC filter enabled.
module tb_eth_axis_header_rx;

    localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        m_hdr_valid;
    logic        m_hdr_ready;
    logic [47:0] m_dest_mac;
    logic [47:0] m_src_mac;
    logic [15:0] m_ethertype;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        busy;
    logic        err_short_frame;
    logic        frame_dropped;

    eth_axis_header_rx #(
        .ENABLE_MAC_FILTER (1'b1),
        .LOCAL_MAC         (LOCAL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .m_hdr_valid     (m_hdr_valid),
        .m_hdr_ready     (m_hdr_ready),
        .m_dest_mac      (m_dest_mac),
        .m_src_mac       (m_src_mac),
        .m_ethertype     (m_ethertype),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .busy            (busy),
        .err_short_frame (err_short_frame),
        .frame_dropped   (frame_dropped)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Payload sink readiness: always ready, or alternating every cycle
    logic toggle_en = 1'b0;
    logic tgl_phase = 1'b0;
    always @(negedge clk) tgl_phase <= ~tgl_phase;
    assign m_axis_tready = !toggle_en || tgl_phase;

    logic [7:0]  tx[$];
    logic [7:0]  rx_data[$];
    logic        rx_last[$];
    logic        rx_user[$];
    logic [47:0] hd_dest[$];
    logic [47:0] hd_src[$];
    logic [15:0] hd_type[$];
    int err_cnt  = 0;
    int drop_cnt = 0;
    int mval_cnt = 0;

    // Observe completed handshakes and pulses on each active edge
    always @(posedge clk) begin
        if (!reset) begin
            if (m_axis_tvalid && m_axis_tready) begin
                rx_data.push_back(m_axis_tdata);
                rx_last.push_back(m_axis_tlast);
                rx_user.push_back(m_axis_tuser);
            end
            if (m_axis_tvalid) mval_cnt++;
            if (m_hdr_valid && m_hdr_ready) begin
                hd_dest.push_back(m_dest_mac);
                hd_src.push_back(m_src_mac);
                hd_type.push_back(m_ethertype);
            end
            if (err_short_frame) err_cnt++;
            if (frame_dropped) drop_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                         input int n, input logic [7:0] base);
        tx.delete();
        for (int i = 5; i >= 0; i--) tx.push_back(d[8*i +: 8]);
        for (int i = 5; i >= 0; i--) tx.push_back(s[8*i +: 8]);
        tx.push_back(t[15:8]);
        tx.push_back(t[7:0]);
        for (int i = 0; i < n; i++) tx.push_back(base + 8'(i));
    endtask

    // Drive the first n bytes of tx; a full frame ends with tvalid released
    task automatic send(input logic user_last, input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            @(negedge clk);
            s_axis_tdata  = tx[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == tx.size() - 1);
            s_axis_tuser  = (i == tx.size() - 1) ? user_last : 1'b0;
            #1;
            t = 0;
            while (!s_axis_tready && t < 400) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (!s_axis_tready) begin
                check("send_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk);
        end
        if (n == tx.size()) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
        end
    endtask

    task automatic drain(input int rb, input int n);
        for (int t = 0; t < 400; t++) begin
            if (rx_data.size() >= rb + n && !m_axis_tvalid) break;
            @(negedge clk);
        end
        #1;
    endtask

    task automatic check_payload(input string tag, input int rb, input int n,
                                 input logic [7:0] base, input logic user_exp);
        int bad;
        bad = 0;
        check({tag, "_count"}, 64'(rx_data.size() - rb), 64'(n));
        for (int i = 0; i < n && rb + i < rx_data.size(); i++) begin
            if (rx_data[rb+i] !== base + 8'(i)) bad++;
            if (rx_last[rb+i] !== (i == n - 1)) bad++;
            if (rx_user[rb+i] !== ((i == n - 1) ? user_exp : 1'b0)) bad++;
        end
        check({tag, "_bytes"}, 64'(bad), 64'd0);
    endtask

    task automatic check_hdr(input string tag, input int hb, input logic [47:0] d,
                             input logic [47:0] s, input logic [15:0] t);
        check({tag, "_hdr_count"}, 64'(hd_dest.size() - hb), 64'd1);
        if (hd_dest.size() > hb) begin
            check({tag, "_dest"}, 64'(hd_dest[hb]), 64'(d));
            check({tag, "_src"}, 64'(hd_src[hb]), 64'(s));
            check({tag, "_type"}, 64'(hd_type[hb]), 64'(t));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, hb, eb, db, mb, acc;

        reset         = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_hdr_ready   = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_hdr_valid", 64'(m_hdr_valid), 64'd0);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_short_frame), 64'd0);
        check("rst_drop", 64'(frame_dropped), 64'd0);
        check("rst_dest", 64'(m_dest_mac), 64'd0);
        check("rst_src", 64'(m_src_mac), 64'd0);
        check("rst_type", 64'(m_ethertype), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // 60-byte frame, free-running sinks
        rb = rx_data.size(); hb = hd_dest.size();
        build(LOCAL, 48'h02_00_00_00_00_02, 16'h0800, 46, 8'h00);
        send(1'b0, tx.size());
        drain(rb, 46);
        check_payload("t1", rb, 46, 8'h00, 1'b0);
        check_hdr("t1", hb, LOCAL, 48'h02_00_00_00_00_02, 16'h0800);
        check("t1_busy_idle", 64'(busy), 64'd0);

        // Toggling payload sink, header held back
        toggle_en   = 1'b1;
        m_hdr_ready = 1'b0;
        rb = rx_data.size(); hb = hd_dest.size();
        send(1'b0, tx.size());
        drain(rb, 46);
        check_payload("t2a", rb, 46, 8'h00, 1'b0);
        check("t2_hdr_pending", 64'(m_hdr_valid), 64'd1);
        @(negedge clk);
        s_axis_tdata  = 8'h02;
        s_axis_tvalid = 1'b1;
        acc = 0;
        repeat (40) begin
            #1;
            if (s_axis_tready) acc++;
            @(negedge clk);
        end
        check("t2_byte0_blocked", 64'(acc), 64'd0);
        check("t2_no_hdr_yet", 64'(hd_dest.size() - hb), 64'd0);
        m_hdr_ready = 1'b1;
        @(posedge clk);
        #1;
        check_hdr("t2a", hb, LOCAL, 48'h02_00_00_00_00_02, 16'h0800);
        rb = rx_data.size(); hb = hd_dest.size();
        build(LOCAL, 48'h02_00_00_00_00_03, 16'h0800, 46, 8'h40);
        send(1'b0, tx.size());
        drain(rb, 46);
        check_payload("t2b", rb, 46, 8'h40, 1'b0);
        check_hdr("t2b", hb, LOCAL, 48'h02_00_00_00_00_03, 16'h0800);
        toggle_en = 1'b0;

        // 10-byte runt frame, then a good frame
        rb = rx_data.size(); hb = hd_dest.size(); eb = err_cnt; mb = mval_cnt;
        build(LOCAL, 48'h02_00_00_00_00_02, 16'h0800, 0, 8'h00);
        while (tx.size() > 10) void'(tx.pop_back());
        send(1'b0, tx.size());
        repeat (3) @(negedge clk);
        check("t3_err_pulses", 64'(err_cnt - eb), 64'd1);
        check("t3_no_hdr", 64'(hd_dest.size() - hb), 64'd0);
        check("t3_no_payload", 64'(mval_cnt - mb), 64'd0);
        check("t3_busy_idle", 64'(busy), 64'd0);
        build(LOCAL, 48'h02_00_00_00_00_04, 16'h0806, 28, 8'h80);
        send(1'b0, tx.size());
        drain(rb, 28);
        check_payload("t3", rb, 28, 8'h80, 1'b0);
        check_hdr("t3", hb, LOCAL, 48'h02_00_00_00_00_04, 16'h0806);

        // Filter: foreign dest dropped, broadcast passed
        rb = rx_data.size(); hb = hd_dest.size(); db = drop_cnt; mb = mval_cnt;
        build(48'h02_00_00_00_00_09, 48'h02_00_00_00_00_02, 16'h0800, 20, 8'h00);
        send(1'b0, tx.size());
        repeat (3) @(negedge clk);
        check("t4_drop_pulses", 64'(drop_cnt - db), 64'd1);
        check("t4_no_hdr", 64'(hd_dest.size() - hb), 64'd0);
        check("t4_no_payload", 64'(mval_cnt - mb), 64'd0);
        build(48'hff_ff_ff_ff_ff_ff, 48'h02_00_00_00_00_07, 16'h0806, 30, 8'h10);
        send(1'b0, tx.size());
        drain(rb, 30);
        check_payload("t4", rb, 30, 8'h10, 1'b0);
        check_hdr("t4", hb, 48'hff_ff_ff_ff_ff_ff, 48'h02_00_00_00_00_07, 16'h0806);
        check("t4_drop_once", 64'(drop_cnt - db), 64'd1);

        // Bad-frame flag on tlast
        rb = rx_data.size();
        build(LOCAL, 48'h02_00_00_00_00_02, 16'h0800, 16, 8'hA0);
        send(1'b1, tx.size());
        drain(rb, 16);
        check_payload("t5", rb, 16, 8'hA0, 1'b1);

        // Reset at payload byte 20
        m_hdr_ready = 1'b0;
        build(LOCAL, 48'h02_00_00_00_00_02, 16'h0800, 46, 8'h00);
        send(1'b0, 34);
        @(negedge clk);
        #1;
        check("t6_pre_hdr_valid", 64'(m_hdr_valid), 64'd1);
        check("t6_pre_busy", 64'(busy), 64'd1);
        s_axis_tdata  = tx[34];
        s_axis_tvalid = 1'b1;
        reset         = 1'b1;
        @(posedge clk);
        #1;
        check("t6_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t6_hdr_valid", 64'(m_hdr_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_tready", 64'(s_axis_tready), 64'd0);
        check("t6_dest_clr", 64'(m_dest_mac), 64'd0);
        @(negedge clk);
        reset         = 1'b0;
        s_axis_tvalid = 1'b0;
        m_hdr_ready   = 1'b1;
        rb = rx_data.size(); hb = hd_dest.size();
        build(LOCAL, 48'h02_00_00_00_00_05, 16'h86dd, 20, 8'hC0);
        send(1'b0, tx.size());
        drain(rb, 20);
        check_payload("t6", rb, 20, 8'hC0, 1'b0);
        check_hdr("t6", hb, LOCAL, 48'h02_00_00_00_00_05, 16'h86dd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
